// File: rtl/frame_buffer_reader_pkg.sv
// Shared types and default geometry for the frame buffer read path.
// The reader FSM states and the output word width live here so the 3dgpu top and benches agree.
package frame_buffer_reader_pkg;

  localparam int OUT_WORD_BITS         = 32;
  localparam int FRAME_BUFFER_ADDR_SIZE = 17;
  localparam int DEF_COLOR_BITS        = 8;
  localparam int DEF_WIDTH             = 320;
  localparam int DEF_HEIGHT            = 240;
  localparam int DEF_NUM_PIXELS        = DEF_WIDTH * DEF_HEIGHT;

  typedef enum logic [2:0] {
    IDLE,
    FLIP,
    READ,
    SEND,
    DONE
  } fbr_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/frame_buffer_reader_pixel_packer.sv
// Packs COLOR_BITS-wide pixels into an OUT_BITS word, lowest slot first.
// Unwritten slots stay zero, so a partial final word comes out zero-padded.
module pixel_packer
  import frame_buffer_reader_pkg::*;
#(
  parameter int COLOR_BITS = DEF_COLOR_BITS,
  parameter int OUT_BITS   = OUT_WORD_BITS,
  localparam int PPW       = OUT_BITS / COLOR_BITS,
  localparam int CNT_W     = $clog2(PPW + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [COLOR_BITS-1:0] pixel_in,
  output logic [OUT_BITS-1:0]   word_out,
  output logic [CNT_W-1:0]      count,
  output logic                  full
);

  logic [OUT_BITS-1:0] word_q, word_d;
  logic [CNT_W-1:0]    count_q, count_d;

  always_comb begin
    word_d  = word_q;
    count_d = count_q;
    if (clear) begin
      word_d  = '0;
      count_d = '0;
    end else if (shift_en) begin
      word_d[count_q*COLOR_BITS +: COLOR_BITS] = pixel_in;
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      count_q <= '0;
    end else begin
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign word_out = word_q;
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(PPW));

endmodule

// File: rtl/frame_buffer_reader.sv
// Read-side consumer of the double-banked frame buffer: flips banks, scans the frame
// row-major with a 1-cycle SRAM latency, and streams packed words under backpressure.
module frame_buffer_reader
  import frame_buffer_reader_pkg::*;
#(
  parameter int ADDR_SIZE  = FRAME_BUFFER_ADDR_SIZE,
  parameter int COLOR_BITS = DEF_COLOR_BITS,
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int OUT_BITS   = OUT_WORD_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  fb_flip,
  output logic [ADDR_SIZE-1:0]  fb_read_addr,
  input  logic [COLOR_BITS-1:0] fb_read_data,
  output logic [OUT_BITS-1:0]   data_out,
  output logic                  data_ready_out,
  input  logic                  write_buffer_full,
  output logic                  busy,
  output logic                  done
);

  localparam int PPW       = OUT_BITS / COLOR_BITS;
  localparam int NUM_WORDS = ceil_div(NUM_PIXELS, PPW);
  localparam int CNT_W     = $clog2(PPW + 1);
  // One spare bit lets the pixel counter reach NUM_PIXELS without wrapping.
  localparam int PIX_W     = ADDR_SIZE + 1;

  localparam logic [PIX_W-1:0]     PIX_END   = PIX_W'(NUM_PIXELS);
  localparam logic [ADDR_SIZE-1:0] LAST_WORD = ADDR_SIZE'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]     PPW_C     = CNT_W'(PPW);
  localparam logic [CNT_W-1:0]     PPW_LAST  = CNT_W'(PPW - 1);

  fbr_state_t           state_q, state_d;
  logic [PIX_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic                 pending_q, pending_d;
  logic [ADDR_SIZE-1:0] words_q, words_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;

  logic                 pk_clear;
  logic                 pk_shift;
  logic [CNT_W-1:0]     pk_count;
  logic                 pk_full;

  pixel_packer #(
    .COLOR_BITS (COLOR_BITS),
    .OUT_BITS   (OUT_BITS)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (pk_clear),
    .shift_en (pk_shift),
    .pixel_in (fb_read_data),
    .word_out (data_out),
    .count    (pk_count),
    .full     (pk_full)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d        = state_q;
    pix_cnt_d      = pix_cnt_q;
    issued_d       = issued_q;
    pending_d      = 1'b0;
    words_d        = words_q;
    addr_d         = addr_q;
    fb_flip        = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    data_ready_out = 1'b0;
    pk_clear       = 1'b0;
    pk_shift       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = FLIP;
      end
      FLIP: begin
        fb_flip   = 1'b1;
        busy      = 1'b1;
        pix_cnt_d = '0;
        issued_d  = '0;
        words_d   = '0;
        pk_clear  = 1'b1;
        state_d   = READ;
      end
      READ: begin
        busy = 1'b1;
        // Issue only addresses that belong to the word being packed.
        if (issued_q != PPW_C && pix_cnt_q != PIX_END) begin
          addr_d    = pix_cnt_q[ADDR_SIZE-1:0];
          pix_cnt_d = pix_cnt_q + PIX_W'(1);
          issued_d  = issued_q + 1'b1;
          pending_d = 1'b1;
        end
        // pix_cnt_q is one past the pixel returning now, so it also flags the frame's last pixel.
        if (pending_q && !pk_full) begin
          pk_shift = 1'b1;
          if (pk_count == PPW_LAST || pix_cnt_q == PIX_END) state_d = SEND;
        end
      end
      SEND: begin
        busy           = 1'b1;
        data_ready_out = 1'b1;
        if (!write_buffer_full) begin
          pk_clear = 1'b1;
          issued_d = '0;
          if (words_q == LAST_WORD) begin
            state_d = DONE;
          end else begin
            words_d = words_q + 1'b1;
            state_d = READ;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      issued_q  <= '0;
      pending_q <= 1'b0;
      words_q   <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      issued_q  <= issued_d;
      pending_q <= pending_d;
      words_q   <= words_d;
      addr_q    <= addr_d;
    end
  end

  // The address is presented in the issuing cycle and held afterwards.
  assign fb_read_addr = addr_d;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Self-checking bench: three reader configurations share clk/rst/start/backpressure,
// each with its own registered SRAM model (mem[i] = i+1) and a word-level reference model.
module tb_frame_buffer_reader;

  localparam int N  = 3;
  localparam int AW = 17;

  int np_t [N] = '{8, 6, 3};
  int cb_t [N] = '{8, 8, 16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b1;
  logic full = 1'b0;

  logic          flip [N];
  logic [AW-1:0] addr [N];
  logic [31:0]   dout [N];
  logic          rdy  [N];
  logic          bsy  [N];
  logic          dn   [N];
  logic [7:0]    rd0, rd1;
  logic [15:0]   rd2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int flips [N] = '{default: 0};
  int dones [N] = '{default: 0};
  int flip_cyc [N] = '{default: 0};
  int done_cyc [N] = '{default: 0};
  int xfer_cyc [N] = '{default: 0};
  logic [31:0] words [N][$];
  logic        blk_q [N] = '{default: 1'b0};
  logic [31:0] blk_word [N];

  int fb [N];
  int db [N];
  int wb [N];
  int s_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rd0 <= 8'(addr[0] + 1);
    rd1 <= 8'(addr[1] + 1);
    rd2 <= 16'(addr[2] + 1);
  end

  frame_buffer_reader #(.ADDR_SIZE(AW), .COLOR_BITS(8), .NUM_PIXELS(8), .OUT_BITS(32)) u0 (
    .clk(clk), .rst(rst), .start(start), .fb_flip(flip[0]), .fb_read_addr(addr[0]),
    .fb_read_data(rd0), .data_out(dout[0]), .data_ready_out(rdy[0]),
    .write_buffer_full(full), .busy(bsy[0]), .done(dn[0]));

  frame_buffer_reader #(.ADDR_SIZE(AW), .COLOR_BITS(8), .NUM_PIXELS(6), .OUT_BITS(32)) u1 (
    .clk(clk), .rst(rst), .start(start), .fb_flip(flip[1]), .fb_read_addr(addr[1]),
    .fb_read_data(rd1), .data_out(dout[1]), .data_ready_out(rdy[1]),
    .write_buffer_full(full), .busy(bsy[1]), .done(dn[1]));

  frame_buffer_reader #(.ADDR_SIZE(AW), .COLOR_BITS(16), .NUM_PIXELS(3), .OUT_BITS(32)) u2 (
    .clk(clk), .rst(rst), .start(start), .fb_flip(flip[2]), .fb_read_addr(addr[2]),
    .fb_read_data(rd2), .data_out(dout[2]), .data_ready_out(rdy[2]),
    .write_buffer_full(full), .busy(bsy[2]), .done(dn[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference word w of a frame: pixel value = address + 1, slot k at bits k*cb.
  function automatic logic [31:0] exp_word(input int np, input int cb, input int w);
    int ppw = 32 / cb;
    logic [31:0] word = '0;
    for (int k = 0; k < ppw; k++) begin
      int idx = w * ppw + k;
      if (idx < np) word |= ((32'(idx + 1)) & ((32'd1 << cb) - 32'd1)) << (k * cb);
    end
    return word;
  endfunction

  function automatic int exp_nwords(input int np, input int cb);
    int ppw = 32 / cb;
    return (np + ppw - 1) / ppw;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (blk_q[i]) begin
        check($sformatf("hold_ready[%0d]", i), 32'(rdy[i]), 32'd1);
        check($sformatf("hold_word[%0d]", i), dout[i], blk_word[i]);
      end
      blk_q[i]    = (rdy[i] === 1'b1) && (full === 1'b1) && (rst === 1'b0);
      blk_word[i] = dout[i];
      if (flip[i] === 1'b1) begin
        flips[i]++;
        flip_cyc[i] = cyc;
      end
      if (rdy[i] === 1'b1 && full === 1'b0 && rst === 1'b0) begin
        words[i].push_back(dout[i]);
        xfer_cyc[i] = cyc;
      end
      if (dn[i] === 1'b1) begin
        dones[i]++;
        done_cyc[i] = cyc;
      end
    end
  end

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (dones[i] <= db[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic start_frame();
    for (int i = 0; i < N; i++) begin
      fb[i] = flips[i];
      db[i] = dones[i];
      wb[i] = words[i].size();
    end
    @(posedge clk); #1;
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    while (n < 400 && !all_done()) begin
      @(posedge clk); #1;
      full = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      n++;
    end
    full = 1'b0;
    check("frame_timeout", 32'(n < 400), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < N; i++) check($sformatf("busy_after_done[%0d]", i), 32'(bsy[i]), 32'd0);
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < N; i++) begin
      int nw = exp_nwords(np_t[i], cb_t[i]);
      check($sformatf("%s_nwords[%0d]", tag, i), 32'(words[i].size() - wb[i]), 32'(nw));
      for (int w = 0; w < nw && wb[i] + w < words[i].size(); w++)
        check($sformatf("%s_word%0d[%0d]", tag, w, i), words[i][wb[i] + w], exp_word(np_t[i], cb_t[i], w));
      check($sformatf("%s_flips[%0d]", tag, i), 32'(flips[i] - fb[i]), 32'd1);
      check($sformatf("%s_dones[%0d]", tag, i), 32'(dones[i] - db[i]), 32'd1);
      check($sformatf("%s_flip_cyc[%0d]", tag, i), 32'(flip_cyc[i]), 32'(s_cyc + 1));
      check($sformatf("%s_done_cyc[%0d]", tag, i), 32'(done_cyc[i]), 32'(xfer_cyc[i] + 1));
    end
  endtask

  task automatic wait_ready0(input string tag);
    int n = 0;
    while (rdy[0] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(rdy[0]), 32'd1);
  endtask

  initial begin
    // 1: reset held two cycles with start high.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        check($sformatf("rst_flip[%0d]", i), 32'(flip[i]), 32'd0);
        check($sformatf("rst_addr[%0d]", i), 32'(addr[i]), 32'd0);
        check($sformatf("rst_dout[%0d]", i), dout[i], 32'd0);
        check($sformatf("rst_ready[%0d]", i), 32'(rdy[i]), 32'd0);
        check($sformatf("rst_busy[%0d]", i), 32'(bsy[i]), 32'd0);
        check($sformatf("rst_done[%0d]", i), 32'(dn[i]), 32'd0);
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) check($sformatf("rst_no_flip[%0d]", i), 32'(flips[i]), 32'd0);

    // 2/4/6: free-running frame on all three configurations.
    start_frame();
    wait_done(1'b0);
    check_frame("free");

    // 3: backpressure for 5 cycles as soon as the first word is offered.
    start_frame();
    wait_ready0("bp_ready_seen");
    full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_word_c%0d", c), dout[0], 32'h0403_0201);
      check($sformatf("bp_ready_c%0d", c), 32'(rdy[0]), 32'd1);
      check($sformatf("bp_addr_c%0d", c), 32'(addr[0] <= AW'(3)), 32'd1);
      @(posedge clk); #1;
    end
    full = 1'b0;
    wait_done(1'b0);
    check_frame("bp");

    // 5a: extra starts during READ and SEND are ignored.
    start_frame();
    repeat (2) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_ready0("xs_ready_seen");
    start = 1'b1;
    full  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    full  = 1'b0;
    wait_done(1'b0);
    check_frame("xstart");

    // 5b: reset while a word is offered aborts the frame.
    start_frame();
    wait_ready0("ab_ready_seen");
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("ab_ready[%0d]", i), 32'(rdy[i]), 32'd0);
      check($sformatf("ab_busy[%0d]", i), 32'(bsy[i]), 32'd0);
      check($sformatf("ab_dout[%0d]", i), dout[i], 32'd0);
      check($sformatf("ab_addr[%0d]", i), 32'(addr[i]), 32'd0);
    end
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("ab_no_done[%0d]", i), 32'(dones[i] - db[i]), 32'd0);
      check($sformatf("ab_one_flip[%0d]", i), 32'(flips[i] - fb[i]), 32'd1);
    end
    start_frame();
    wait_done(1'b0);
    check_frame("restart");

    // Randomized downstream backpressure against the reference model.
    for (int r = 0; r < 4; r++) begin
      start_frame();
      wait_done(1'b1);
      check_frame($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
